// File: rtl/soc_system_pio_cmd.sv
// Avalon-MM PIO for command/status handshakes.
// Command side: DATA register driven straight onto out_port, with OUTSET/OUTCLEAR
// write aliases and optional auto-clearing pulse bits that stay high PULSE_LEN cycles.
// Status side: two-flop synchroniser, rising-edge capture with W1C, masked level irq.
module soc_system_pio_cmd #(
    parameter int              DW         = 1,
    parameter int              IW         = 1,
    parameter logic [DW-1:0]   PULSE_MASK = '0,
    parameter int              PULSE_LEN  = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic [DW-1:0] out_port,
    input  logic [IW-1:0] in_port,
    output logic          irq
);

    localparam logic [15:0] PCNT_RELOAD = 16'(PULSE_LEN - 1);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SYNC   = 3'd1;
    localparam logic [2:0] A_EDGE   = 3'd2;
    localparam logic [2:0] A_MASK   = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    logic [DW-1:0] data_out_q, data_out_d;
    logic [15:0]   pcnt_q, pcnt_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] sync1_q, sync2_q, sync2_prev_q;
    logic [IW-1:0] edge_cap_q, edge_cap_d;
    logic [IW-1:0] irq_mask_q, irq_mask_d;

    logic          wr;
    logic          wr_data, wr_set, wr_clr, wr_edge, wr_mask;
    logic          reload;
    logic [DW-1:0] wd_dw;
    logic [IW-1:0] wd_iw;

    // Upper writedata bits are intentionally ignored when DW/IW < 32.
    logic unused_wd;
    assign unused_wd = &{1'b0, writedata};

    assign wd_dw   = writedata[DW-1:0];
    assign wd_iw   = writedata[IW-1:0];
    assign wr      = chipselect & ~write_n;
    assign wr_data = wr && (address == A_DATA);
    assign wr_set  = wr && (address == A_OUTSET);
    assign wr_clr  = wr && (address == A_OUTCLR);
    assign wr_edge = wr && (address == A_EDGE);
    assign wr_mask = wr && (address == A_MASK);

    // A write that drives any pulse bit high (re)arms the pulse timer.
    assign reload  = (wr_data | wr_set) && |(wd_dw & PULSE_MASK);

    // Command register next state: bus writes first, then pulse timer expiry.
    always_comb begin
        data_out_d = data_out_q;
        pcnt_d     = pcnt_q;
        busy_d     = busy_q;
        if (wr_data) data_out_d = wd_dw;
        if (wr_set)  data_out_d = data_out_q | wd_dw;
        if (wr_clr)  data_out_d = data_out_q & ~wd_dw;
        if (reload) begin
            // Retrigger wins over expiry so the pulse extends without a low glitch.
            pcnt_d = PCNT_RELOAD;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (pcnt_q != 16'd0) begin
                pcnt_d = pcnt_q - 16'd1;
            end else begin
                data_out_d = data_out_d & ~PULSE_MASK;
                busy_d     = 1'b0;
            end
        end
    end

    // Status next state: new edges take priority over a same-cycle W1C.
    always_comb begin
        edge_cap_d = (edge_cap_q & ~(wr_edge ? wd_iw : '0)) | (sync2_q & ~sync2_prev_q);
        irq_mask_d = wr_mask ? wd_iw : irq_mask_q;
    end

    // Command register and pulse timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= '0;
            pcnt_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            pcnt_q     <= pcnt_d;
            busy_q     <= busy_d;
        end
    end

    // Input synchroniser, edge history, captured edges and irq mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync2_prev_q <= '0;
            edge_cap_q   <= '0;
            irq_mask_q   <= '0;
        end else begin
            sync1_q      <= in_port;
            sync2_q      <= sync1_q;
            sync2_prev_q <= sync2_q;
            edge_cap_q   <= edge_cap_d;
            irq_mask_q   <= irq_mask_d;
        end
    end

    // Zero-wait-state read mux; busy occupies bit 31 of SYNC_IN.
    always_comb begin
        readdata = '0;
        case (address)
            A_DATA: readdata[DW-1:0] = data_out_q;
            A_SYNC: begin
                readdata[IW-1:0] = sync2_q;
                readdata[31]     = busy_q;
            end
            A_EDGE: readdata[IW-1:0] = edge_cap_q;
            A_MASK: readdata[IW-1:0] = irq_mask_q;
            default: readdata = '0;
        endcase
    end

    assign out_port = data_out_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_cmd.sv
// Scoreboarded random + directed bench for soc_system_pio_cmd (DW=4, IW=2,
// pulse bit 0, 3-cycle pulse). A behavioural model predicts readdata/out_port/irq
// for every cycle; a separate monitor pops predictions and compares them.
module tb_soc_system_pio_cmd;

    localparam int DW = 4;
    localparam int IW = 2;
    localparam logic [3:0] PMASK = 4'b0001;
    localparam int PLEN = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic [IW-1:0] in_port = '0;
    logic          irq;

    soc_system_pio_cmd #(.DW(DW), .IW(IW), .PULSE_MASK(PMASK), .PULSE_LEN(PLEN)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic [3:0]  outp;
        logic        irq;
        logic [2:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: rem = cycles of pulse still to run (busy while >0);
    // hist[k] = in_port as seen k+1 clock edges ago.
    logic [3:0] m_data;
    int         m_rem;
    logic [1:0] m_mask, m_edge;
    logic [1:0] hist [3];

    function automatic void model_reset();
        m_data = '0; m_rem = 0; m_mask = '0; m_edge = '0;
        for (int k = 0; k < 3; k++) hist[k] = '0;
    endfunction

    function automatic exp_t model_out(input logic [2:0] a);
        exp_t e;
        e.rd = '0;
        case (a)
            3'd0: e.rd[3:0] = m_data;
            3'd1: begin e.rd[1:0] = hist[1]; e.rd[31] = (m_rem > 0); end
            3'd2: e.rd[1:0] = m_edge;
            3'd3: e.rd[1:0] = m_mask;
            default: e.rd = '0;
        endcase
        e.outp = m_data;
        e.irq  = |(m_edge & m_mask);
        e.addr = a;
        return e;
    endfunction

    function automatic void model_step(input logic cs, input logic wn, input logic [2:0] a,
                                       input logic [31:0] wd, input logic [1:0] inp);
        logic       wr;
        logic [3:0] nd;
        logic [1:0] rise;
        wr = cs && !wn;
        // Edge seen when synchronised value was 0 one cycle and 1 the next.
        rise   = hist[1] & ~hist[2];
        m_edge = (m_edge & ~((wr && a == 3'd2) ? wd[1:0] : 2'b00)) | rise;
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = inp;
        if (wr && a == 3'd3) m_mask = wd[1:0];
        nd = m_data;
        if (wr && a == 3'd0) nd = wd[3:0];
        if (wr && a == 3'd4) nd = m_data | wd[3:0];
        if (wr && a == 3'd5) nd = m_data & ~wd[3:0];
        if (wr && (a == 3'd0 || a == 3'd4) && (wd[3:0] & PMASK) != 0) begin
            m_rem = PLEN;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) nd = nd & ~PMASK;
        end
        m_data = nd;
    endfunction

    // Called at a negedge: drive inputs, predict, let the monitor check, clock it in.
    task automatic cyc(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd, input logic [1:0] inp);
        chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = inp;
        #1;
        exp_q.push_back(model_out(a));
        ->sample_ev;
        @(posedge clk);
        model_step(cs, wn, a, wd, inp);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b1, 1'b0, a, wd, in_port);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b1, 1'b1, a, 32'h0, in_port);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 3'd0, 32'h0, in_port);
    endtask

    task automatic set_in(input logic [1:0] v);
        cyc(1'b0, 1'b1, 3'd2, 32'h0, v);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_reset();
        reset_n = 1'b0;
        chipselect = 1'b0; write_n = 1'b1;
        model_reset();
        for (int a = 0; a < 4; a++) begin
            address = 3'(a);
            #1;
            exp_q.push_back(model_out(3'(a)));
            ->sample_ev;
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: compare each presented sample against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty got rd=%h out=%h irq=%b", readdata, out_port, irq);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (readdata !== e.rd) begin
                    errors++;
                    $display("FAIL readdata addr=%0d got %h expected %h at %0t", e.addr, readdata, e.rd, $time);
                end
                checks++;
                if (out_port !== e.outp) begin
                    errors++;
                    $display("FAIL out_port got %h expected %h at %0t", out_port, e.outp, $time);
                end
                checks++;
                if (irq !== e.irq) begin
                    errors++;
                    $display("FAIL irq got %b expected %b at %0t", irq, e.irq, $time);
                end
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Basic pulse: 0x3 -> 0x3 for 3 cycles, then 0x2; busy visible on SYNC_IN.
        wr(3'd0, 32'h3);
        rd(3'd1); rd(3'd1); rd(3'd1); rd(3'd0); rd(3'd1);

        // Retrigger in the expiry cycle.
        wr(3'd0, 32'h1);
        idle(2);
        wr(3'd0, 32'h1);
        rd(3'd0); rd(3'd0); rd(3'd0); rd(3'd0);

        // OUTSET/OUTCLEAR on non-pulse bits.
        wr(3'd0, 32'h2); idle(4);
        wr(3'd4, 32'h9); wr(3'd5, 32'h2); rd(3'd0);
        // OUTCLEAR ends a pulse early; timer still runs out.
        wr(3'd4, 32'h1); wr(3'd5, 32'h1); rd(3'd1); rd(3'd1); rd(3'd1); rd(3'd0);

        // Edge capture, irq, W1C and edge-vs-W1C collision.
        wr(3'd3, 32'h2);
        set_in(2'b10); idle(3); rd(3'd2);
        wr(3'd2, 32'h2); rd(3'd2);
        set_in(2'b00); idle(3);
        set_in(2'b10); idle(1);
        wr(3'd2, 32'h2); rd(3'd2);
        wr(3'd2, 32'h3); rd(3'd2);

        // Empty addresses and ignored writes.
        rd(3'd4); rd(3'd5); rd(3'd6); rd(3'd7);
        wr(3'd1, 32'hFFFF_FFFF); wr(3'd6, 32'hFFFF_FFFF); wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0); rd(3'd1); rd(3'd2); rd(3'd3);

        // Reset mid-pulse, with in_port already high across release.
        wr(3'd0, 32'hF); idle(1);
        in_port = 2'b11;
        pulse_reset();
        rd(3'd2); rd(3'd2); rd(3'd2); rd(3'd2);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] wd;
            logic [1:0]  inp;
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                wd  = $urandom;
                if ($urandom_range(0, 3) == 0) wd[0] = 1'b1;
                inp = ($urandom_range(0, 5) == 0) ? 2'($urandom) : in_port;
                cyc(($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), wd, inp);
            end
        end

        #1;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_system_pio_cmd.md
SOC_SYSTEM_PIO_CMD -- requirements
Module: soc_system_pio_cmd

Interface
REQ-001 SHALL have parameter DW, default 1, meaning command output width, legal range 1..32.
REQ-002 SHALL have parameter IW, default 1, meaning status input width, legal range 1..32.
REQ-003 SHALL have parameter PULSE_MASK, default 0 (DW bits), meaning bits set to 1 are auto-clearing pulse bits.
REQ-004 SHALL have parameter PULSE_LEN, default 1, meaning pulse-bit high time in clk cycles, legal range 1..65535.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port address, input, 3, meaning Avalon-MM word address.
REQ-008 SHALL have port chipselect, input, 1, meaning slave select.
REQ-009 SHALL have port write_n, input, 1, meaning active-low write strobe.
REQ-010 SHALL have port writedata, input, 32, meaning write data; only bits [DW-1:0] or [IW-1:0] used.
REQ-011 SHALL have port readdata, output, 32, meaning read data, zero-extended.
REQ-012 SHALL have port out_port, output, DW, meaning command register value.
REQ-013 SHALL have port in_port, input, IW, meaning asynchronous status/done inputs.
REQ-014 SHALL have port irq, output, 1, meaning level interrupt.

Function
REQ-015 SHALL perform a write only when chipselect=1 and write_n=0; the addressed register updates on that clk edge.
REQ-016 SHALL drive readdata combinationally from address, 0 wait states: 0=DATA, 1=SYNC_IN, 2=EDGE, 3=IRQ_MASK, 4/5=0, 6/7=0.
REQ-017 SHALL implement address 0 (DATA): write loads data_out[DW-1:0]; read returns data_out.
REQ-018 SHALL implement address 4 (OUTSET, write-only): data_out |= writedata[DW-1:0].
REQ-019 SHALL implement address 5 (OUTCLEAR, write-only): data_out &= ~writedata[DW-1:0].
REQ-020 SHALL drive out_port = data_out directly, with no extra register stage.
REQ-021 SHALL keep a 16-bit pulse counter pcnt and a busy flag; busy is readable at SYNC_IN bit 31.
REQ-022 SHALL, when a DATA or OUTSET write sets any PULSE_MASK bit to 1, load pcnt=PULSE_LEN-1 and set busy=1 on that edge.
REQ-023 SHALL, while busy=1 with pcnt>0 and no reload, decrement pcnt each cycle.
REQ-024 SHALL, while busy=1 with pcnt=0 and no reload, clear all PULSE_MASK bits of data_out and set busy=0; pulse bits are therefore high exactly PULSE_LEN cycles.
REQ-025 SHALL give a reload in the expiry cycle priority: the written value persists and pcnt reloads (retrigger extends the pulse).
REQ-026 SHALL let OUTCLEAR of pulse bits end the pulse early; busy still runs to expiry, and the expiry clears nothing further.
REQ-027 SHALL leave non-PULSE_MASK bits unaffected by the pulse logic.
REQ-028 SHALL synchronise in_port through two flops (sync2); SYNC_IN read returns sync2 in bits [IW-1:0].
REQ-029 SHALL capture rising edges: edge_cap[i] sets when sync2[i]=1 and the previous-cycle sync2[i]=0.
REQ-030 SHALL implement address 2 (EDGE): read returns edge_cap; write clears each bit whose writedata bit is 1 (W1C).
REQ-031 SHALL, when a new edge and a W1C clear hit the same bit in the same cycle, leave the bit set.
REQ-032 SHALL implement address 3 (IRQ_MASK): read/write, IW bits.
REQ-033 SHALL drive irq = |(edge_cap & irq_mask) as a registered-free combinational OR.
REQ-034 SHALL ignore writes to addresses 1, 6 and 7.

Reset
REQ-035 SHALL, on reset_n=0, asynchronously clear data_out, pcnt, busy, sync flops, edge_cap and irq_mask; out_port=0, irq=0.
REQ-036 SHALL abort any pulse in progress on reset: no residual pulse after release.
REQ-037 SHALL not detect an edge in the first cycle after reset release when in_port is already high; an edge is detected two cycles later, via sync2.

Verification
REQ-038 DW=4, PULSE_MASK=4'b0001, PULSE_LEN=3: write DATA=0x3 -> out_port=0x3 for 3 cycles, then 0x2; busy high during those 3 cycles.
REQ-039 Same config, rewrite DATA=0x1 in the expiry cycle -> bit0 stays high 3 more cycles, with no low glitch.
REQ-040 OUTSET 0x8 then OUTCLEAR 0x2 from 0x3 -> out_port 0xB then 0x9; read DATA returns 0x9.
REQ-041 IW=2, irq_mask=0x2: raise in_port[1] -> EDGE=0x2 and irq=1 three edges later; W1C 0x2 -> irq=0; edge coincident with W1C -> bit stays 1.
REQ-042 Assert reset_n mid-pulse (pcnt=1) -> out_port=0 immediately, busy=0, all reads return 0.
REQ-043 Read addresses 4-7 -> readdata=0; write address 1 -> no state change.
